mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset. Ports: clk input 1 (rising-edge clock); resetn input 1 (synchronous, active-low reset).
REQ-002 The block SHALL have the following upstream ports (all inputs, width 1 unless stated):
- ex_valid 1, instruction offered;
- ex_pc 32;
- ex_result 32, ALU result or memory address;
- ex_rkd 32, store data;
- ex_memop 8, one-hot {ld_b,ld_bu,ld_h,ld_hu,ld_w,st_b,st_h,st_w};
- ex_gr_we 1;
- ex_rf_waddr 5.
REQ-003 mem_allowin output 1: the stage accepts an instruction this cycle.
REQ-004 The block SHALL have the following data-SRAM ports:
- outputs: data_req 1, data_wr 1, data_size 2 (0=byte, 1=half, 2=word), data_wstrb 4, data_addr 32, data_wdata 32;
- inputs: data_addr_ok 1, data_data_ok 1, data_rdata 32.
REQ-005 The block SHALL have the following forwarding outputs: fwd_valid 1, fwd_addr 5, fwd_data 32, fwd_ld_pending 1.
REQ-006 The block SHALL have the following downstream ports: wb_allowin input 1; wb_valid, wb_pc 32, wb_gr_we, wb_rf_waddr 5, wb_rf_wdata 32 outputs, all registered.

Function
REQ-007 mem_allowin SHALL equal ~m_valid | (ready_go & wb_allowin), combinationally. An instruction is captured into internal registers at a clock edge where ex_valid & mem_allowin.
REQ-008 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
- Capture of a memory op (any ex_memop bit) goes to REQ; capture of a non-memory op goes to (or stays in) IDLE.
- REQ goes to WAIT when data_addr_ok.
- WAIT goes to DONE when data_data_ok & ~wb_allowin; it goes directly to IDLE when data_data_ok & wb_allowin, unless a new op is captured that cycle.
- DONE goes to IDLE when wb_allowin, unless a new op is captured.
REQ-009 ready_go SHALL be 1 for a non-memory op, 1 in WAIT & data_data_ok, and 1 in DONE; it is 0 otherwise.
REQ-010 data_req SHALL be high only in REQ with m_valid. data_addr, data_wr, data_size, data_wstrb and data_wdata SHALL be held stable from the request until data_addr_ok.
REQ-011 Store encoding (addr[1:0] = a):
- st_b: data_wstrb = 4'b0001<<a, data_wdata = {4{rkd[7:0]}};
- st_h: data_wstrb = 4'b0011<<a, data_wdata = {2{rkd[15:0]}};
- st_w: data_wstrb = 4'hF, data_wdata = rkd.
Loads SHALL drive data_wstrb = 0.
REQ-012 Load extraction (a = addr[1:0]):
- ld_b / ld_bu: byte a, sign-extended / zero-extended;
- ld_h / ld_hu: halfword a[1], sign-extended / zero-extended;
- ld_w: full word.
data_rdata SHALL be captured into a holding register at data_data_ok, so the result survives a WB stall.
REQ-013 Misaligned access (half with a[0]=1, word with a≠0) SHALL NOT issue data_req. The op SHALL complete as a non-memory op with wb_gr_we = 0.
REQ-014 wb_rf_wdata SHALL be the extracted load data for loads and ex_result otherwise.
REQ-015 The wb_* registers SHALL load {1, pc, gr_we, waddr, wdata} when m_valid & ready_go & wb_allowin. They SHALL load wb_valid = 0 when wb_allowin & ~(m_valid & ready_go), and SHALL hold otherwise.
REQ-016 Forwarding outputs:
- fwd_valid = m_valid & gr_we & ready_go; fwd_addr = waddr; fwd_data = the final wdata.
- fwd_ld_pending = m_valid & load & ~ready_go, so ID stalls.
REQ-017 A data_data_ok received in IDLE or REQ SHALL be ignored. At most one transaction SHALL be outstanding.
REQ-018 Stores SHALL also wait for data_data_ok before ready_go.

Reset
REQ-019 With resetn=0 at a rising edge, the block SHALL force state=IDLE, m_valid=0, wb_valid=0, wb_gr_we=0, wb_pc=0, wb_rf_waddr=0, wb_rf_wdata=0, and the holding register to 0.
REQ-020 Reset SHALL abandon any in-flight transaction. data_req SHALL be 0 during reset and in the first cycle after it.

Verification
REQ-021 Scenario: non-memory op pc=0x1C000000, result=0x55, waddr=3, wb_allowin=1 -> next edge wb_valid=1, wb_rf_wdata=0x55, wb_rf_waddr=3, and data_req never asserts.
REQ-022 Scenario: ld_b at addr 0x103, addr_ok delayed 2 cycles, data_ok 1 cycle later with rdata=0x80AABBCC -> wb_rf_wdata=0xFFFFFF80. The same access with ld_bu -> 0x00000080.
REQ-023 Scenario: st_h at addr 0x202, rkd=0x1234ABCD -> data_wstrb=4'b1100, data_wdata=0xABCDABCD, data_wr=1, data_size=1; mem_allowin stays 0 until data_ok.
REQ-024 Scenario: ld_w completes with rdata=0xDEADBEEF while wb_allowin=0 for 3 cycles -> state DONE, fwd_valid=1 with fwd_data=0xDEADBEEF; when wb_allowin rises, wb_rf_wdata=0xDEADBEEF.
REQ-025 Scenario: resetn low for 1 cycle while in WAIT, then data_data_ok pulses -> state IDLE, wb_valid=0, the pulse is ignored, and no spurious write-back occurs.
REQ-026 Scenario: ld_h at addr 0x301 -> no data_req, wb_valid=1, wb_gr_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues at most one
// data-SRAM transaction, extracts load data and feeds the write-back stage.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_rkd,
    input  logic [7:0]  ex_memop,
    input  logic        ex_gr_we,
    input  logic [4:0]  ex_rf_waddr,
    output logic        mem_allowin,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic        fwd_ld_pending,
    input  logic        wb_allowin,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_gr_we,
    output logic [4:0]  wb_rf_waddr,
    output logic [31:0] wb_rf_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // memop bit order: {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w}

    function automatic logic misaligned(input logic half, input logic word, input logic [1:0] a);
        return (half & a[0]) | (word & (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] st, input logic [1:0] a);
        logic [3:0] strb;
        if (st[0]) begin
            strb = 4'hF;
        end else if (st[1]) begin
            strb = 4'b0011 << a;
        end else if (st[2]) begin
            strb = 4'b0001 << a;
        end else begin
            strb = 4'h0;
        end
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic st_b, input logic st_h, input logic [31:0] rkd);
        logic [31:0] d;
        if (st_b) begin
            d = {4{rkd[7:0]}};
        end else if (st_h) begin
            d = {2{rkd[15:0]}};
        end else begin
            d = rkd;
        end
        return d;
    endfunction

    function automatic logic [31:0] load_data(input logic [4:0] ld, input logic [1:0] a, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        if (ld[4]) begin
            d = {{24{b[7]}}, b};
        end else if (ld[3]) begin
            d = {24'h000000, b};
        end else if (ld[2]) begin
            d = {{16{h[15]}}, h};
        end else if (ld[1]) begin
            d = {16'h0000, h};
        end else if (ld[0]) begin
            d = word;
        end else begin
            d = 32'h00000000;
        end
        return d;
    endfunction

    state_t      state_r;
    state_t      state_base_s;
    state_t      state_nxt_s;
    logic        m_valid_r;
    logic [31:0] pc_r;
    logic [31:0] result_r;
    logic [31:0] rkd_r;
    logic [7:0]  memop_r;
    logic        gr_we_r;
    logic [4:0]  waddr_r;
    logic [31:0] hold_r;
    logic        ready_go_s;
    logic        capture_s;
    logic        ex_misalign_s;
    logic        ex_mem_s;
    logic        is_load_s;
    logic        byte_op_s;
    logic        half_op_s;
    logic [31:0] load_val_s;
    logic [31:0] wdata_s;

    assign ex_misalign_s = misaligned(ex_memop[5] | ex_memop[4] | ex_memop[1],
                                      ex_memop[3] | ex_memop[0], ex_result[1:0]);
    assign ex_mem_s      = (|ex_memop) & ~ex_misalign_s;
    assign mem_allowin   = ~m_valid_r | (ready_go_s & wb_allowin);
    assign capture_s     = ex_valid & mem_allowin;

    assign is_load_s = |memop_r[7:3];
    assign byte_op_s = memop_r[7] | memop_r[6] | memop_r[2];
    assign half_op_s = memop_r[5] | memop_r[4] | memop_r[1];

    // Per-state completion flag and next state ignoring a new capture
    always_comb begin
        ready_go_s   = 1'b0;
        state_base_s = state_r;
        case (state_r)
            IDLE: begin
                ready_go_s   = 1'b1;
                state_base_s = IDLE;
            end
            REQ: begin
                if (data_addr_ok) begin
                    state_base_s = WAIT;
                end else begin
                    state_base_s = REQ;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    ready_go_s   = 1'b1;
                    state_base_s = wb_allowin ? IDLE : DONE;
                end else begin
                    state_base_s = WAIT;
                end
            end
            DONE: begin
                ready_go_s   = 1'b1;
                state_base_s = wb_allowin ? IDLE : DONE;
            end
            default: begin
                ready_go_s   = 1'b0;
                state_base_s = IDLE;
            end
        endcase
    end

    // A newly captured op overrides the per-state transition
    always_comb begin
        state_nxt_s = state_base_s;
        if (capture_s) begin
            state_nxt_s = ex_mem_s ? REQ : IDLE;
        end else begin
            state_nxt_s = state_base_s;
        end
    end

    // Stage register and FSM state; misaligned ops are demoted to non-memory ops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= IDLE;
            m_valid_r <= 1'b0;
            pc_r      <= 32'h00000000;
            result_r  <= 32'h00000000;
            rkd_r     <= 32'h00000000;
            memop_r   <= 8'h00;
            gr_we_r   <= 1'b0;
            waddr_r   <= 5'd0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                m_valid_r <= 1'b1;
                pc_r      <= ex_pc;
                result_r  <= ex_result;
                rkd_r     <= ex_rkd;
                memop_r   <= ex_misalign_s ? 8'h00 : ex_memop;
                gr_we_r   <= ex_gr_we & ~ex_misalign_s;
                waddr_r   <= ex_rf_waddr;
            end else if (m_valid_r & ready_go_s & wb_allowin) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    // Keep the returned read word so it survives a write-back stall
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_r <= 32'h00000000;
        end else if ((state_r == WAIT) && data_data_ok) begin
            hold_r <= data_rdata;
        end
    end

    // Final write-back data: extracted load value or the ALU result
    always_comb begin
        load_val_s = load_data(memop_r[7:3], result_r[1:0],
                               (state_r == DONE) ? hold_r : data_rdata);
        if (is_load_s) begin
            wdata_s = load_val_s;
        end else begin
            wdata_s = result_r;
        end
    end

    assign data_req   = m_valid_r & (state_r == REQ);
    assign data_wr    = |memop_r[2:0];
    assign data_size  = byte_op_s ? 2'd0 : (half_op_s ? 2'd1 : 2'd2);
    assign data_wstrb = store_strb(memop_r[2:0], result_r[1:0]);
    assign data_addr  = result_r;
    assign data_wdata = store_data(memop_r[2], memop_r[1], rkd_r);

    assign fwd_valid      = m_valid_r & gr_we_r & ready_go_s;
    assign fwd_addr       = waddr_r;
    assign fwd_data       = wdata_s;
    assign fwd_ld_pending = m_valid_r & is_load_s & ~ready_go_s;

    // Write-back pipeline register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid    <= 1'b0;
            wb_pc       <= 32'h00000000;
            wb_gr_we    <= 1'b0;
            wb_rf_waddr <= 5'd0;
            wb_rf_wdata <= 32'h00000000;
        end else if (m_valid_r & ready_go_s & wb_allowin) begin
            wb_valid    <= 1'b1;
            wb_pc       <= pc_r;
            wb_gr_we    <= gr_we_r;
            wb_rf_waddr <= waddr_r;
            wb_rf_wdata <= wdata_s;
        end else if (wb_allowin) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [31:0] ex_rkd;
    logic [7:0]  ex_memop;
    logic        ex_gr_we;
    logic [4:0]  ex_rf_waddr;
    logic        mem_allowin;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        fwd_ld_pending;
    logic        wb_allowin;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_gr_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int req_base = 0;

    mem_stage dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result), .ex_rkd(ex_rkd),
        .ex_memop(ex_memop), .ex_gr_we(ex_gr_we), .ex_rf_waddr(ex_rf_waddr),
        .mem_allowin(mem_allowin),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_ld_pending(fwd_ld_pending),
        .wb_allowin(wb_allowin), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_gr_we(wb_gr_we),
        .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with an active request
    always @(posedge clk) begin
        if (data_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rd,
                           input logic [31:0] exp, input string tag);
        ex_valid = 1'b1; ex_memop = op; ex_result = addr; ex_pc = 32'h1C000100;
        ex_gr_we = 1'b1; ex_rf_waddr = 5'd7;
        tick();
        ex_valid = 1'b0; ex_memop = 8'h00;
        #1;
        chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_wstrb"}, {28'd0, data_wstrb}, 32'd0);
        chk({tag, "_pending"}, {31'd0, fwd_ld_pending}, 32'd1);
        chk({tag, "_allowin"}, {31'd0, mem_allowin}, 32'd0);
        tick();
        #1;
        chk({tag, "_req_held"}, {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk({tag, "_req_drop"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_wait_allowin"}, {31'd0, mem_allowin}, 32'd0);
        data_data_ok = 1'b1; data_rdata = rd;
        #1;
        chk({tag, "_fwd"}, fwd_data, exp);
        chk({tag, "_ok_allowin"}, {31'd0, mem_allowin}, 32'd1);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wb_wdata"}, wb_rf_wdata, exp);
        chk({tag, "_wb_waddr"}, {27'd0, wb_rf_waddr}, 32'd7);
    endtask

    task automatic do_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rkd,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                            input logic [1:0] exp_size, input string tag);
        ex_valid = 1'b1; ex_memop = op; ex_result = addr; ex_rkd = rkd;
        ex_gr_we = 1'b0; ex_rf_waddr = 5'd0;
        tick();
        ex_valid = 1'b0; ex_memop = 8'h00;
        #1;
        chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
        chk({tag, "_wr"}, {31'd0, data_wr}, 32'd1);
        chk({tag, "_size"}, {30'd0, data_size}, {30'd0, exp_size});
        chk({tag, "_wstrb"}, {28'd0, data_wstrb}, {28'd0, exp_strb});
        chk({tag, "_wdata"}, data_wdata, exp_wdata);
        chk({tag, "_allowin_req"}, {31'd0, mem_allowin}, 32'd0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk({tag, "_allowin_wait"}, {31'd0, mem_allowin}, 32'd0);
        tick();
        #1;
        chk({tag, "_allowin_wait2"}, {31'd0, mem_allowin}, 32'd0);
        data_data_ok = 1'b1;
        #1;
        chk({tag, "_allowin_ok"}, {31'd0, mem_allowin}, 32'd1);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wb_gr_we"}, {31'd0, wb_gr_we}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; ex_valid = 1'b0; ex_pc = 32'h0; ex_result = 32'h0; ex_rkd = 32'h0;
        ex_memop = 8'h00; ex_gr_we = 1'b0; ex_rf_waddr = 5'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0; wb_allowin = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_wdata", wb_rf_wdata, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_allowin", {31'd0, mem_allowin}, 32'd1);
        resetn = 1'b1;
        tick();
        #1;
        chk("post_rst_req", {31'd0, data_req}, 32'd0);

        // Non-memory op
        req_base = req_cnt;
        ex_valid = 1'b1; ex_pc = 32'h1C000000; ex_result = 32'h55; ex_gr_we = 1'b1;
        ex_rf_waddr = 5'd3; ex_memop = 8'h00;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        chk("alu_fwd_data", fwd_data, 32'h55);
        chk("alu_fwd_addr", {27'd0, fwd_addr}, 32'd3);
        tick();
        #1;
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_wb_wdata", wb_rf_wdata, 32'h55);
        chk("alu_wb_waddr", {27'd0, wb_rf_waddr}, 32'd3);
        chk("alu_wb_pc", wb_pc, 32'h1C000000);
        chk("alu_no_req", req_cnt, req_base);
        tick();
        #1;
        chk("alu_bubble", {31'd0, wb_valid}, 32'd0);

        // Loads with byte/half extraction
        do_load(8'h80, 32'h00000103, 32'h80AABBCC, 32'hFFFFFF80, "ldb");
        do_load(8'h40, 32'h00000103, 32'h80AABBCC, 32'h00000080, "ldbu");
        do_load(8'h80, 32'h00000100, 32'h80AABBCC, 32'hFFFFFFCC, "ldb0");
        do_load(8'h20, 32'h00000302, 32'h80AABBCC, 32'hFFFF80AA, "ldh");
        do_load(8'h10, 32'h00000302, 32'h80AABBCC, 32'h000080AA, "ldhu");

        // Stores
        do_store(8'h02, 32'h00000202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 2'd1, "sth");
        do_store(8'h04, 32'h00000201, 32'h000000EF, 4'b0010, 32'hEFEFEFEF, 2'd0, "stb");
        do_store(8'h01, 32'h00000200, 32'h11223344, 4'b1111, 32'h11223344, 2'd2, "stw");

        // Load word completing under a write-back stall
        ex_valid = 1'b1; ex_memop = 8'h08; ex_result = 32'h400; ex_gr_we = 1'b1;
        ex_rf_waddr = 5'd9; ex_pc = 32'h1C000200;
        tick();
        ex_valid = 1'b0; ex_memop = 8'h00;
        #1;
        chk("ldw_size", {30'd0, data_size}, 32'd2);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; wb_allowin = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
        chk("ldw_stall_allowin", {31'd0, mem_allowin}, 32'd0);
        chk("ldw_fwd_ok", fwd_data, 32'hDEADBEEF);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("ldw_done_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        chk("ldw_done_fwd_data", fwd_data, 32'hDEADBEEF);
        chk("ldw_done_fwd_addr", {27'd0, fwd_addr}, 32'd9);
        chk("ldw_done_req", {31'd0, data_req}, 32'd0);
        chk("ldw_done_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        #1;
        chk("ldw_done_hold", fwd_data, 32'hDEADBEEF);
        chk("ldw_done_allowin", {31'd0, mem_allowin}, 32'd0);
        wb_allowin = 1'b1;
        #1;
        chk("ldw_release_allowin", {31'd0, mem_allowin}, 32'd1);
        tick();
        #1;
        chk("ldw_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ldw_wb_wdata", wb_rf_wdata, 32'hDEADBEEF);
        chk("ldw_wb_pc", wb_pc, 32'h1C000200);

        // Reset while waiting for data, then a stray data_ok
        ex_valid = 1'b1; ex_memop = 8'h08; ex_result = 32'h500; ex_gr_we = 1'b1; ex_rf_waddr = 5'd2;
        tick();
        ex_valid = 1'b0; ex_memop = 8'h00;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("rstw_allowin", {31'd0, mem_allowin}, 32'd1);
        chk("rstw_req", {31'd0, data_req}, 32'd0);
        chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstw_wb_wdata", wb_rf_wdata, 32'd0);
        chk("rstw_pending", {31'd0, fwd_ld_pending}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        #1;
        chk("rstw_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        #1;
        chk("rstw_no_wb2", {31'd0, wb_valid}, 32'd0);
        chk("rstw_wdata2", wb_rf_wdata, 32'd0);

        // Misaligned half load
        req_base = req_cnt;
        ex_valid = 1'b1; ex_memop = 8'h20; ex_result = 32'h301; ex_gr_we = 1'b1; ex_rf_waddr = 5'd4;
        #1;
        chk("mis_allowin", {31'd0, mem_allowin}, 32'd1);
        tick();
        ex_valid = 1'b0; ex_memop = 8'h00;
        #1;
        chk("mis_req", {31'd0, data_req}, 32'd0);
        chk("mis_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("mis_pending", {31'd0, fwd_ld_pending}, 32'd0);
        tick();
        #1;
        chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis_wb_gr_we", {31'd0, wb_gr_we}, 32'd0);
        chk("mis_wb_wdata", wb_rf_wdata, 32'h301);
        chk("mis_no_req", req_cnt, req_base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
